// File: rtl/res_wb.sv
// res_wb: session-based writeback FIFO steering result words to the even/odd bank write ports.
module res_wb #(
   parameter int DW    = 64,
   parameter int AW    = 10,
   parameter int DEPTH = 4
) (
   input  logic                       ck,
   input  logic                       rst,
   input  logic                       i_start,
   input  logic                       i_done,
   input  logic                       i_valid,
   input  logic [DW-1:0]              i_data,
   input  logic                       i_ev_odd_n,
   input  logic [AW-1:0]              i_even_addr,
   input  logic [AW-1:0]              i_odd_addr,
   input  logic                       i_even_rdy,
   input  logic                       i_odd_rdy,
   output logic                       o_even_we,
   output logic                       o_odd_we,
   output logic [AW-1:0]              o_even_addr,
   output logic [AW-1:0]              o_odd_addr,
   output logic [DW-1:0]              o_even_data,
   output logic [DW-1:0]              o_odd_data,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty,
   output logic                       o_ovf,
   output logic                       o_err,
   output logic [15:0]                o_wr_cnt,
   output logic                       o_wb_done
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state, state_nx;
   logic [PW-1:0] wp, rp;
   logic full_q, empty, active, push_req, push, pop, head_bank;
   logic          bank_m [DEPTH];
   logic [AW-1:0] addr_m [DEPTH];
   logic [DW-1:0] data_m [DEPTH];
   // equal pointers are ambiguous, so a full flag disambiguates full from empty
   assign o_count   = full_q ? CW'(DEPTH) : {1'b0, wp - rp};
   assign empty     = o_count == '0;
   assign head_bank = bank_m[rp];
   assign pop       = !empty && (head_bank ? i_odd_rdy : i_even_rdy);
   assign active    = state == RUN || state == DRAIN;
   assign push_req  = i_valid && active;
   assign push      = push_req && (!full_q || pop);
   always_comb begin
      state_nx = state == IDLE  ? (i_start ? RUN : IDLE) :
                 state == RUN   ? (i_done ? DRAIN : RUN) :
                 state == DRAIN ? (empty && !push ? DONE : DRAIN) : IDLE;
   end
   always_ff @(posedge ck) begin
      if (rst) begin
         state    <= IDLE;
         wp       <= '0;
         rp       <= '0;
         full_q   <= 1'b0;
         o_ovf    <= 1'b0;
         o_err    <= 1'b0;
         o_wr_cnt <= '0;
      end else begin
         state <= state_nx;
         if (push) wp <= wp + PW'(1);
         if (pop) rp <= rp + PW'(1);
         if (push != pop) full_q <= push && (wp + PW'(1) == rp);
         if (push_req && full_q && !pop) o_ovf <= 1'b1;
         if (i_valid && !active) o_err <= 1'b1;
         if (state == IDLE && i_start) o_wr_cnt <= '0;
         else if (pop) o_wr_cnt <= o_wr_cnt + 16'd1;
      end
   end
   always_ff @(posedge ck) begin
      if (push) begin
         bank_m[wp] <= i_ev_odd_n;
         addr_m[wp] <= i_ev_odd_n ? i_odd_addr : i_even_addr;
         data_m[wp] <= i_data;
      end
   end
   assign o_even_we   = pop && !head_bank;
   assign o_odd_we    = pop && head_bank;
   assign o_even_addr = (!empty && !head_bank) ? addr_m[rp] : '0;
   assign o_odd_addr  = (!empty && head_bank) ? addr_m[rp] : '0;
   assign o_even_data = (!empty && !head_bank) ? data_m[rp] : '0;
   assign o_odd_data  = (!empty && head_bank) ? data_m[rp] : '0;
   assign o_full      = full_q;
   assign o_empty     = empty;
   assign o_wb_done   = state == DONE;
endmodule
